pipe_ctrl_nstage: RTL and testbench

//  Parametrised valid/ready pipeline controller for the NN accelerator datapath.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_nstage_if.sv | 27 ++
 rtl/pipe_ctrl_slot.sv | 33 +++
 rtl/pipe_ctrl_nstage.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl_nstage.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller.
// State encoding and occupancy-width helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_nstage_if.sv
// Feeder/consumer handshake bundle.
// master = environment side, slave = controller side.
interface pipe_ctrl_nstage_if;

  logic valid;
  logic ready;
  logic valid_out;
  logic ready_out;
  logic flush;

  modport master (
    output valid,
    output ready_out,
    output flush,
    input  ready,
    input  valid_out
  );

  modport slave (
    input  valid,
    input  ready_out,
    input  flush,
    output ready,
    output valid_out
  );

endinterface

// File: rtl/pipe_ctrl_slot.sv
// One pipeline stage valid bit.
// Loads on enable, clears when its beat moves on.
module pipe_ctrl_slot (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic rdy,
  input  logic taken,
  output logic en,
  output logic v,
  output logic v_next
);

  assign en = src & rdy;

  // next valid: load, hand off, or hold
  always_comb begin
    v_next = v;
    if (en)
      v_next = 1'b1;
    else if (v & rdy & taken)
      v_next = 1'b0;
  end

  // valid bit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      v <= 1'b0;
    else
      v <= v_next;
  end

endmodule

// File: rtl/pipe_ctrl_nstage.sv
// Valid/ready pipeline controller with per-stage enables,
// occupancy count and a drain/flush sequence.
module pipe_ctrl_nstage
  import pipe_ctrl_pkg::*;
#(
  parameter  int STAGES   = 3,
  parameter  bit COLLAPSE = 1'b1,
  localparam int CNT_W    = cnt_w(STAGES)
) (
  input  logic                clk,
  input  logic                reset,
  pipe_ctrl_nstage_if.slave   bus,
  output logic [STAGES-1:0]   enable,
  output logic [CNT_W-1:0]    occupancy,
  output logic                busy,
  output logic                flush_done
);

  state_t state;
  state_t state_next;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] taken;
  logic [CNT_W-1:0]  occ_next;
  logic              acc;
  logic              drain_done;

  if (COLLAPSE) begin : g_collapse
    // a stage is ready if any stage at or after it can move
    always_comb begin
      logic r;
      r = !v[STAGES-1] | bus.ready_out;
      rdy = '0;
      rdy[STAGES-1] = r;
      for (int i = STAGES - 2; i >= 0; i--) begin
        r = !v[i] | r;
        rdy[i] = r;
      end
    end
  end else begin : g_global
    // whole pipe freezes while the result waits
    always_comb begin
      rdy = {STAGES{!(v[STAGES-1] & !bus.ready_out)}};
    end
  end

  assign bus.ready = rdy[0] & (state != ST_DRAIN) & !bus.flush;
  assign bus.valid_out = v[STAGES-1];
  assign acc = bus.valid & bus.ready;
  assign busy = (state != ST_IDLE);

  // a stage is emptied when the next one takes its beat
  always_comb begin
    taken = '0;
    for (int i = 0; i < STAGES - 1; i++)
      taken[i] = enable[i+1];
    taken[STAGES-1] = bus.ready_out;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic src;
    if (i == 0) begin : g_head
      assign src = acc;
    end else begin : g_body
      assign src = v[i-1];
    end
    pipe_ctrl_slot u_slot (
      .clk    (clk),
      .reset  (reset),
      .src    (src),
      .rdy    (rdy[i]),
      .taken  (taken[i]),
      .en     (enable[i]),
      .v      (v[i]),
      .v_next (v_next[i])
    );
  end

  // popcount of the next valid vector
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < STAGES; i++)
      occ_next = occ_next + CNT_W'(v_next[i]);
  end

  assign drain_done = (state == ST_DRAIN) && (occ_next == '0);

  // state transitions; flush beats a same-cycle accept
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.flush)
          state_next = ST_DRAIN;
        else if (acc)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.flush)
          state_next = ST_DRAIN;
        else if (occ_next == '0)
          state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (occ_next == '0)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // state, occupancy and drain-complete pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      occupancy  <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      occupancy  <= occ_next;
      flush_done <= drain_done;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_nstage.sv
// Bench for pipe_ctrl_nstage: collapse and global-stall
// instances driven together, checked against a beat model.
module tb_pipe_ctrl_nstage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic ro = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_nstage_if bc ();
  pipe_ctrl_nstage_if bg ();

  assign bc.valid = valid;
  assign bc.ready_out = ro;
  assign bc.flush = flush;
  assign bg.valid = valid;
  assign bg.ready_out = ro;
  assign bg.flush = flush;

  logic [2:0] en_c, en_g;
  logic [1:0] occ_c, occ_g;
  logic busy_c, busy_g, fd_c, fd_g;

  pipe_ctrl_nstage #(.STAGES(3), .COLLAPSE(1'b1)) u_col (
    .clk        (clk),
    .reset      (reset),
    .bus        (bc),
    .enable     (en_c),
    .occupancy  (occ_c),
    .busy       (busy_c),
    .flush_done (fd_c)
  );

  pipe_ctrl_nstage #(.STAGES(3), .COLLAPSE(1'b0)) u_glb (
    .clk        (clk),
    .reset      (reset),
    .bus        (bg),
    .enable     (en_g),
    .occupancy  (occ_g),
    .busy       (busy_g),
    .flush_done (fd_g)
  );

  logic [1:0] ready_o, vout_o, busy_o, fd_o;
  logic [2:0] en_o [2];
  logic [1:0] occ_o [2];

  assign ready_o = {bg.ready, bc.ready};
  assign vout_o  = {bg.valid_out, bc.valid_out};
  assign busy_o  = {busy_g, busy_c};
  assign fd_o    = {fd_g, fd_c};
  assign en_o[0] = en_c;
  assign en_o[1] = en_g;
  assign occ_o[0] = occ_c;
  assign occ_o[1] = occ_g;

  // model: index 0 collapses bubbles, index 1 stalls globally
  // mst: 0 idle, 1 run, 2 drain
  bit mv [2][3];
  int mst [2];
  bit mfd [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) mv[k][i] = 1'b0;
      mst[k] = 0;
      mfd[k] = 1'b0;
    end
  endtask

  function automatic bit blocked(int k);
    if (k == 0) return mv[k][0] && mv[k][1] && mv[k][2] && !ro;
    return mv[k][2] && !ro;
  endfunction

  function automatic bit exp_ready(int k);
    return !blocked(k) && (mst[k] != 2) && !flush;
  endfunction

  function automatic logic [2:0] exp_en(int k);
    logic [2:0] e;
    bit room;
    e = '0;
    e[0] = valid && exp_ready(k);
    for (int i = 1; i < 3; i++) begin
      if (k == 0) begin
        room = ro;
        for (int j = i; j < 3; j++) if (!mv[k][j]) room = 1'b1;
        e[i] = mv[k][i-1] && room;
      end else begin
        e[i] = mv[k][i-1] && !blocked(k);
      end
    end
    return e;
  endfunction

  function automatic int exp_occ(int k);
    return int'(mv[k][0]) + int'(mv[k][1]) + int'(mv[k][2]);
  endfunction

  // advance the model by one clock using the current inputs
  task automatic tick();
    bit nv [2][3];
    int ns [2];
    bit nfd [2];
    bit a [3];
    bit acc;
    int cnt;
    for (int k = 0; k < 2; k++) begin
      acc = valid && exp_ready(k);
      for (int i = 0; i < 3; i++) a[i] = mv[k][i];
      if (k == 0) begin
        if (a[2] && ro) a[2] = 1'b0;
        for (int i = 1; i >= 0; i--)
          if (a[i] && !a[i+1]) begin
            a[i+1] = 1'b1;
            a[i] = 1'b0;
          end
        if (acc) a[0] = 1'b1;
      end else if (!blocked(k)) begin
        a[2] = a[1];
        a[1] = a[0];
        a[0] = acc;
      end
      cnt = int'(a[0]) + int'(a[1]) + int'(a[2]);
      ns[k] = mst[k];
      case (mst[k])
        0: if (flush) ns[k] = 2; else if (acc) ns[k] = 1;
        1: if (flush) ns[k] = 2; else if (cnt == 0) ns[k] = 0;
        default: if (cnt == 0) ns[k] = 0;
      endcase
      nfd[k] = (mst[k] == 2) && (cnt == 0);
      for (int i = 0; i < 3; i++) nv[k][i] = a[i];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) mv[k][i] = nv[k][i];
      mst[k] = ns[k];
      mfd[k] = nfd[k];
    end
    #1;
  endtask

  task automatic drain(int n);
    valid = 1'b0;
    flush = 1'b0;
    ro = 1'b1;
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (occ_o[k] !== 2'(exp_occ(k))) begin
          failures++;
          $display("FAIL drain_occ dut%0d got=%0d exp=%0d", k, occ_o[k], exp_occ(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    ro = 1'b0;
    flush = 1'b0;
    model_clear();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 6;
      if (ready_o[k] !== 1'b1) begin
        failures++; $display("FAIL rst_ready dut%0d got=%b exp=1", k, ready_o[k]);
      end
      if (vout_o[k] !== 1'b0) begin
        failures++; $display("FAIL rst_vout dut%0d got=%b exp=0", k, vout_o[k]);
      end
      if (busy_o[k] !== 1'b0) begin
        failures++; $display("FAIL rst_busy dut%0d got=%b exp=0", k, busy_o[k]);
      end
      if (fd_o[k] !== 1'b0) begin
        failures++; $display("FAIL rst_fd dut%0d got=%b exp=0", k, fd_o[k]);
      end
      if (occ_o[k] !== 2'd0) begin
        failures++; $display("FAIL rst_occ dut%0d got=%0d exp=0", k, occ_o[k]);
      end
      if (en_o[k] !== 3'b000) begin
        failures++; $display("FAIL rst_en dut%0d got=%b exp=000", k, en_o[k]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    valid = 1'b1;
    ro = 1'b1;
    flush = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks += 2;
        if (vout_o[k] !== 1'(n >= 3)) begin
          failures++;
          $display("FAIL lat_vout dut%0d cyc=%0d got=%b exp=%b", k, n, vout_o[k], n >= 3);
        end
        if (ready_o[k] !== 1'b1) begin
          failures++; $display("FAIL lat_ready dut%0d cyc=%0d got=%b exp=1", k, n, ready_o[k]);
        end
      end
      tick();
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    valid = 1'b1;
    ro = 1'b0;
    flush = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ready_o[k] !== 1'(n < 3)) begin
          failures++;
          $display("FAIL bp_ready dut%0d cyc=%0d got=%b exp=%b", k, n, ready_o[k], n < 3);
        end
        if (n >= 3) begin
          checks += 2;
          if (vout_o[k] !== 1'b1) begin
            failures++; $display("FAIL bp_vout dut%0d cyc=%0d got=%b exp=1", k, n, vout_o[k]);
          end
          if (occ_o[k] !== 2'd3) begin
            failures++; $display("FAIL bp_occ dut%0d cyc=%0d got=%0d exp=3", k, n, occ_o[k]);
          end
        end
      end
      tick();
    end
    drain(4);
  endtask

  task automatic test_gap();
    ro = 1'b0;
    flush = 1'b0;
    for (int n = 0; n < 6; n++) begin
      valid = (n == 0) || (n == 2);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (en_o[k] !== exp_en(k)) begin
          failures++;
          $display("FAIL gap_en dut%0d cyc=%0d got=%b exp=%b", k, n, en_o[k], exp_en(k));
        end
      end
      if (vout_o[1]) begin
        checks++;
        if (en_o[1] !== 3'b000) begin
          failures++; $display("FAIL gap_stall_en dut1 cyc=%0d got=%b exp=000", n, en_o[1]);
        end
      end
      if (n == 5) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (occ_o[k] !== 2'd2) begin
            failures++; $display("FAIL gap_occ dut%0d got=%0d exp=2", k, occ_o[k]);
          end
        end
      end
      tick();
    end
    drain(4);
  endtask

  task automatic test_flush();
    int pulses [2];
    ro = 1'b0;
    valid = 1'b1;
    flush = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (occ_o[k] !== 2'd2) begin
        failures++; $display("FAIL fl_occ dut%0d got=%0d exp=2", k, occ_o[k]);
      end
      if (ready_o[k] !== 1'b0) begin
        failures++; $display("FAIL fl_ready dut%0d got=%b exp=0", k, ready_o[k]);
      end
    end
    tick();
    flush = 1'b0;
    valid = 1'b0;
    ro = 1'b1;
    pulses[0] = 0;
    pulses[1] = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (fd_o[k] === 1'b1) pulses[k]++;
        checks++;
        if (fd_o[k] !== mfd[k]) begin
          failures++; $display("FAIL fl_fd dut%0d cyc=%0d got=%b exp=%b", k, n, fd_o[k], mfd[k]);
        end
        if (busy_o[k]) begin
          checks++;
          if (ready_o[k] !== 1'b0) begin
            failures++; $display("FAIL fl_drain_ready dut%0d cyc=%0d got=%b exp=0", k, n, ready_o[k]);
          end
        end
      end
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 3;
      if (pulses[k] != 1) begin
        failures++; $display("FAIL fl_pulses dut%0d got=%0d exp=1", k, pulses[k]);
      end
      if (busy_o[k] !== 1'b0) begin
        failures++; $display("FAIL fl_busy dut%0d got=%b exp=0", k, busy_o[k]);
      end
      if (occ_o[k] !== 2'd0) begin
        failures++; $display("FAIL fl_occ_end dut%0d got=%0d exp=0", k, occ_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    valid = 1'b1;
    ro = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (ready_o[k] !== 1'b0) begin
        failures++; $display("FAIL fi_ready dut%0d got=%b exp=0", k, ready_o[k]);
      end
      if (en_o[k] !== 3'b000) begin
        failures++; $display("FAIL fi_en dut%0d got=%b exp=000", k, en_o[k]);
      end
    end
    tick();
    flush = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (busy_o[k] !== 1'b1) begin
        failures++; $display("FAIL fi_busy dut%0d got=%b exp=1", k, busy_o[k]);
      end
      if (fd_o[k] !== 1'b0) begin
        failures++; $display("FAIL fi_fd_early dut%0d got=%b exp=0", k, fd_o[k]);
      end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks += 2;
      if (fd_o[k] !== 1'b1) begin
        failures++; $display("FAIL fi_fd dut%0d got=%b exp=1", k, fd_o[k]);
      end
      if (busy_o[k] !== 1'b0) begin
        failures++; $display("FAIL fi_idle dut%0d got=%b exp=0", k, busy_o[k]);
      end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fd_o[k] !== 1'b0) begin
        failures++; $display("FAIL fi_fd_once dut%0d got=%b exp=0", k, fd_o[k]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    valid = 1'b1;
    ro = 1'b0;
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (occ_o[k] !== 2'd3) begin
        failures++; $display("FAIL rm_full dut%0d got=%0d exp=3", k, occ_o[k]);
      end
    end
    tick();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks += 4;
      if (vout_o[k] !== 1'b0) begin
        failures++; $display("FAIL rm_vout dut%0d got=%b exp=0", k, vout_o[k]);
      end
      if (ready_o[k] !== 1'b1) begin
        failures++; $display("FAIL rm_ready dut%0d got=%b exp=1", k, ready_o[k]);
      end
      if (occ_o[k] !== 2'd0) begin
        failures++; $display("FAIL rm_occ dut%0d got=%0d exp=0", k, occ_o[k]);
      end
      if (busy_o[k] !== 1'b0) begin
        failures++; $display("FAIL rm_busy dut%0d got=%b exp=0", k, busy_o[k]);
      end
    end
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      valid = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks += 6;
        if (ready_o[k] !== exp_ready(k)) begin
          failures++; $display("FAIL rnd_ready dut%0d cyc=%0d got=%b exp=%b", k, n, ready_o[k], exp_ready(k));
        end
        if (en_o[k] !== exp_en(k)) begin
          failures++; $display("FAIL rnd_en dut%0d cyc=%0d got=%b exp=%b", k, n, en_o[k], exp_en(k));
        end
        if (vout_o[k] !== mv[k][2]) begin
          failures++; $display("FAIL rnd_vout dut%0d cyc=%0d got=%b exp=%b", k, n, vout_o[k], mv[k][2]);
        end
        if (occ_o[k] !== 2'(exp_occ(k))) begin
          failures++; $display("FAIL rnd_occ dut%0d cyc=%0d got=%0d exp=%0d", k, n, occ_o[k], exp_occ(k));
        end
        if (busy_o[k] !== 1'(mst[k] != 0)) begin
          failures++; $display("FAIL rnd_busy dut%0d cyc=%0d got=%b exp=%b", k, n, busy_o[k], mst[k] != 0);
        end
        if (fd_o[k] !== mfd[k]) begin
          failures++; $display("FAIL rnd_fd dut%0d cyc=%0d got=%b exp=%b", k, n, fd_o[k], mfd[k]);
        end
      end
      tick();
    end
    drain(6);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_gap();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
